// File: rtl/alu_pkg.sv
// Shared widths, opcodes and word type for the 6-bit ALU.
package alu_pkg;
  localparam int WIDTH   = 6;
  localparam int SHAMT_W = 3;

  localparam logic OP_XANDOR = 1'b0;
  localparam logic OP_SHR    = 1'b1;

  typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/alu_shifter.sv
// Combinational right shifter with carry-out of the last bit shifted out.
// Build option ALU_ARITH_SHR_EN: arithmetic (sign-fill) shift instead of zero-fill.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   r,
  output logic               carry
);

  logic                 fill;
  logic [2*WIDTH+1:0]   ext;

`ifdef ALU_ARITH_SHR_EN
  assign fill = a[WIDTH-1];
`else
  assign fill = 1'b0;
`endif

  // A guard slot below the LSB catches the last bit shifted out; the fill
  // region is one bit wider than A so a shift of 7 still yields all-fill.
  assign ext          = {{(WIDTH+1){fill}}, a, 1'b0};
  assign {r, carry}   = (WIDTH+1)'(ext >> shamt);

endmodule

// File: rtl/alu.sv
// 6-bit two-function ALU (XANDOR / SHR) with registered result and flags.
// Build option ALU_ARITH_SHR_EN selects arithmetic SHR inside alu_shifter.
module alu
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             OP,
  output logic             out_valid,
  output logic [WIDTH-1:0] R,
  output logic             CF,
  output logic             SF,
  output logic             ZF
);

  logic [WIDTH-1:0] shr_r;
  logic             shr_c;
  logic [WIDTH-1:0] res_r;
  logic             res_c;

  alu_shifter u_shifter (
    .a     (A),
    .shamt (B[SHAMT_W-1:0]),
    .r     (shr_r),
    .carry (shr_c)
  );

  always_comb begin
    res_r = (A ^ B) & (A | B);
    res_c = 1'b0;
    if (OP == OP_SHR) begin
      res_r = shr_r;
      res_c = shr_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      R         <= '0;
      CF        <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        R  <= res_r;
        CF <= res_c;
      end
    end
  end

  // Flags come straight off the registered result so they can never lag R.
  assign SF = R[WIDTH-1];
  assign ZF = (R == '0);

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, corner sequences, random vs model.
module tb_alu;

  localparam int W = 6;
`ifdef ALU_ARITH_SHR_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         OP = 1'b0;
  logic         out_valid;
  logic [W-1:0] R;
  logic         CF, SF, ZF;

  int errors = 0;
  int checks = 0;

  alu dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .OP        (OP),
    .out_valid (out_valid),
    .R         (R),
    .CF        (CF),
    .SF        (SF),
    .ZF        (ZF)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic [W-1:0] exp_r;
    logic         exp_cf;
  } vec_t;

  vec_t vecs[12];

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic exp_v,
                           input logic [W-1:0] exp_r, input logic exp_cf);
    check_bit({name, ".out_valid"}, out_valid, exp_v);
    checks++;
    if (R !== exp_r) begin
      errors++;
      $display("FAIL %s.R: got %b expected %b", name, R, exp_r);
    end
    check_bit({name, ".CF"}, CF, exp_cf);
    check_bit({name, ".SF"}, SF, exp_r[W-1]);
    check_bit({name, ".ZF"}, ZF, (exp_r == '0));
  endtask

  // Reference model: shift one bit at a time, remembering what falls out.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic op);
    logic [W-1:0] r;
    logic         c;
    logic         fill;
    if (op == 1'b0) return {a ^ b, 1'b0};
    r    = a;
    c    = 1'b0;
    fill = ARITH ? a[W-1] : 1'b0;
    for (int k = 0; k < int'(b[2:0]); k++) begin
      c = r[0];
      r = {fill, r[W-1:1]};
    end
    return {r, c};
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic op);
    in_valid = v;
    A  = a;
    B  = b;
    OP = op;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] last_r;
    logic         last_cf;
    logic [W:0]   m;
    logic [W-1:0] ra, rb;
    logic         rop, rv;

    vecs[0]  = '{"xandor_alt",   6'b101010, 6'b010101, 1'b0, 6'b111111, 1'b0};
    vecs[1]  = '{"shr_by1",      6'b101011, 6'b000001, 1'b1,
                 ARITH ? 6'b110101 : 6'b010101, 1'b1};
    vecs[2]  = '{"xandor_zero",  6'b110011, 6'b110011, 1'b0, 6'b000000, 1'b0};
    vecs[3]  = '{"shr_by6",      6'b111111, 6'b000110, 1'b1,
                 ARITH ? 6'b111111 : 6'b000000, 1'b1};
    vecs[4]  = '{"shr_by7_pos",  6'b011011, 6'b000111, 1'b1, 6'b000000, 1'b0};
    vecs[5]  = '{"shr_by7_neg",  6'b100000, 6'b000111, 1'b1,
                 ARITH ? 6'b111111 : 6'b000000, ARITH};
    vecs[6]  = '{"shr_by0_hiB",  6'b100110, 6'b111000, 1'b1, 6'b100110, 1'b0};
    vecs[7]  = '{"shr_by2_hiB",  6'b010110, 6'b101010, 1'b1, 6'b000101, 1'b1};
    vecs[8]  = '{"shr_by3_neg",  6'b110100, 6'b000011, 1'b1,
                 ARITH ? 6'b111110 : 6'b000110, 1'b1};
    vecs[9]  = '{"xandor_zeros", 6'b000000, 6'b000000, 1'b0, 6'b000000, 1'b0};
    vecs[10] = '{"xandor_mix",   6'b111000, 6'b001111, 1'b0, 6'b110111, 1'b0};
    vecs[11] = '{"shr_by5_neg",  6'b100001, 6'b000101, 1'b1,
                 ARITH ? 6'b111111 : 6'b000001, 1'b0};

    // Reset applied with no clock edge in between must act immediately.
    rst = 1'b1;
    #2;
    check_out("reset_async", 1'b0, 6'b000000, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, back-to-back with in_valid held high.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].op);
      @(posedge clk);
      #1;
      check_out(vecs[i].name, 1'b1, vecs[i].exp_r, vecs[i].exp_cf);
    end

    // Idle cycle: out_valid drops, result and flags hold despite new operands.
    last_r  = vecs[11].exp_r;
    last_cf = vecs[11].exp_cf;
    @(negedge clk);
    drive(1'b0, 6'b101010, 6'b010101, 1'b0);
    @(posedge clk);
    #1;
    check_out("hold_idle1", 1'b0, last_r, last_cf);
    @(posedge clk);
    #1;
    check_out("hold_idle2", 1'b0, last_r, last_cf);

    // Two back-to-back ops, then reset in the middle of a pending third.
    @(negedge clk);
    drive(1'b1, 6'b101011, 6'b000001, 1'b1);
    @(posedge clk);
    #1;
    check_out("b2b_first", 1'b1, ARITH ? 6'b110101 : 6'b010101, 1'b1);
    @(negedge clk);
    drive(1'b1, 6'b101010, 6'b010101, 1'b0);
    @(posedge clk);
    #1;
    check_out("b2b_second", 1'b1, 6'b111111, 1'b0);
    @(negedge clk);
    drive(1'b1, 6'b111111, 6'b000110, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_out("reset_midstream", 1'b0, 6'b000000, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 1'b0, 6'b000000, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 6'b111111, 6'b000110, 1'b1);
    @(posedge clk);
    #1;
    check_out("post_reset_idle", 1'b0, 6'b000000, 1'b0);

    // Random operands, opcodes and valid gaps against the model.
    last_r  = '0;
    last_cf = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      ra  = W'($urandom_range(0, 63));
      rb  = W'($urandom_range(0, 63));
      rop = 1'($urandom_range(0, 1));
      rv  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      drive(rv, ra, rb, rop);
      if (rv) begin
        m       = model(ra, rb, rop);
        last_r  = m[W:1];
        last_cf = m[0];
      end
      @(posedge clk);
      #1;
      check_out("random", rv, last_r, last_cf);
    end

    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
